// File: rtl/vend_pkg.sv
// Shared encodings for the coin feeder and the vending block it talks to.
package vend_pkg;

  // Coin codes on the din bus
  localparam logic [1:0] DIN_NONE = 2'd0;
  localparam logic [1:0] DIN_5    = 2'd1;
  localparam logic [1:0] DIN_10   = 2'd2;

  // Drink select encodings
  localparam logic DRINK_A = 1'b0;
  localparam logic DRINK_B = 1'b1;

  // Prices in coin-value units
  localparam int PRICE_A = 5;
  localparam int PRICE_B = 10;

  typedef enum logic [1:0] {
    RESP_OK       = 2'd0,
    RESP_NO_FUNDS = 2'd1,
    RESP_MISMATCH = 2'd2,
    RESP_TIMEOUT  = 2'd3
  } resp_status_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_COIN = 3'd1,
    S_GAP  = 3'd2,
    S_WAIT = 3'd3,
    S_RESP = 3'd4
  } state_e;

  // Face value of a coin code; DIN_NONE is worth nothing
  function automatic int coin_value(logic [1:0] code);
    case (code)
      DIN_5:   return 5;
      DIN_10:  return 10;
      default: return 0;
    endcase
  endfunction

  function automatic int drink_price(logic drink);
    return (drink == DRINK_B) ? PRICE_B : PRICE_A;
  endfunction

endpackage

// File: rtl/coin_feeder_if.sv
// Host-side request/refill/response signals plus the vendor coin bus.
//
// Handshake: a request transfers on a rising clk edge where both req_valid
// and req_ready are high; req_ready is high only while the feeder is idle.
// resp_valid is a one-cycle strobe with no back-pressure; resp_status is
// meaningful in that cycle only. refill_valid is honoured only while idle.
interface coin_feeder_if #(
  parameter int CW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_drink;
  logic          refill_valid;
  logic [CW-1:0] refill_n5;
  logic [CW-1:0] refill_n10;
  logic [CW-1:0] n5_cnt;
  logic [CW-1:0] n10_cnt;
  logic          sel;
  logic [1:0]    din;
  logic [1:0]    drinks_in;
  logic          change_in;
  logic          resp_valid;
  logic [1:0]    resp_status;
  vend_pkg::state_e state_dbg;

  // Feeder side
  modport slave (
    input  req_valid, req_drink, refill_valid, refill_n5, refill_n10,
           drinks_in, change_in,
    output req_ready, n5_cnt, n10_cnt, sel, din, resp_valid, resp_status,
           state_dbg
  );

  // Host/vendor side
  modport master (
    output req_valid, req_drink, refill_valid, refill_n5, refill_n10,
           drinks_in, change_in,
    input  req_ready, n5_cnt, n10_cnt, sel, din, resp_valid, resp_status,
           state_dbg
  );
endinterface

// File: rtl/coin_planner.sv
// Combinational coin choice for one purchase from the current inventory.
module coin_planner
  import vend_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic [CW-1:0] n5,
  input  logic [CW-1:0] n10,
  input  logic          drink,
  output logic [1:0]    coin_cnt,
  output logic [1:0]    coin0,
  output logic [1:0]    coin1,
  output logic          exp_change,
  output logic          funds_ok
);

  int paid;

  // Drink A prefers a single 5; drink B prefers a single 10 over two 5s
  always_comb begin
    coin_cnt   = 2'd0;
    coin0      = DIN_NONE;
    coin1      = DIN_NONE;
    funds_ok   = 1'b0;
    if (drink == DRINK_A) begin
      if (n5 != '0) begin
        coin_cnt = 2'd1;
        coin0    = DIN_5;
        funds_ok = 1'b1;
      end else if (n10 != '0) begin
        coin_cnt = 2'd1;
        coin0    = DIN_10;
        funds_ok = 1'b1;
      end
    end else begin
      if (n10 != '0) begin
        coin_cnt = 2'd1;
        coin0    = DIN_10;
        funds_ok = 1'b1;
      end else if (n5 >= CW'(2)) begin
        coin_cnt = 2'd2;
        coin0    = DIN_5;
        coin1    = DIN_5;
        funds_ok = 1'b1;
      end
    end
    // Overpayment can only ever be one 5-coin with these prices
    paid       = coin_value(coin0) + coin_value(coin1);
    exp_change = funds_ok && (paid > drink_price(drink));
  end

endmodule

// File: rtl/coin_feeder.sv
// Drives coins into the vending block for one purchase at a time, then
// checks the drink/change reply and reports a status.
module coin_feeder
  import vend_pkg::*;
#(
  parameter int CW          = 8,
  parameter int COIN_GAP    = 1,
  parameter int TIMEOUT_CYC = 8
) (
  input logic          clk,
  input logic          rst_n,
  coin_feeder_if.slave bus
);

  localparam int              WW        = $clog2(TIMEOUT_CYC);
  localparam logic [3:0]      GAP_LAST  = 4'(COIN_GAP - 1);
  localparam logic [WW-1:0]   WAIT_LAST = WW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]   CNT_MAX   = {CW{1'b1}};

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic [1:0]    din_q, din_d;
  logic          resp_valid_q, resp_valid_d;
  resp_status_e  resp_status_q, resp_status_d;
  logic [CW-1:0] n5_q, n5_d;
  logic [CW-1:0] n10_q, n10_d;
  logic [3:0]    gap_q, gap_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0]    coin1_q, coin1_d;
  logic          more_q, more_d;
  logic          exp_chg_q, exp_chg_d;
  logic          drink_q, drink_d;

  logic [CW-1:0] n5_eff, n10_eff;
  logic [1:0]    plan_cnt, plan_coin0, plan_coin1;
  logic          plan_chg, plan_ok;
  logic          issue;
  logic [1:0]    issue_code;
  logic [1:0]    drink_code;

  // A refill in the acceptance cycle is visible to the planner
  always_comb begin
    n5_eff  = n5_q;
    n10_eff = n10_q;
    if (state_q == S_IDLE && bus.refill_valid) begin
      n5_eff  = bus.refill_n5;
      n10_eff = bus.refill_n10;
    end
  end

  coin_planner #(.CW(CW)) u_planner (
    .n5         (n5_eff),
    .n10        (n10_eff),
    .drink      (bus.req_drink),
    .coin_cnt   (plan_cnt),
    .coin0      (plan_coin0),
    .coin1      (plan_coin1),
    .exp_change (plan_chg),
    .funds_ok   (plan_ok)
  );

  assign drink_code = {1'b0, drink_q} + 2'd1;

  // Next-state, registered outputs and inventory updates
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    din_d         = DIN_NONE;
    resp_valid_d  = 1'b0;
    resp_status_d = resp_status_q;
    n5_d          = n5_q;
    n10_d         = n10_q;
    gap_d         = gap_q;
    wait_d        = wait_q;
    coin1_d       = coin1_q;
    more_d        = more_q;
    exp_chg_d     = exp_chg_q;
    drink_d       = drink_q;
    issue         = 1'b0;
    issue_code    = DIN_NONE;

    case (state_q)
      S_IDLE: begin
        n5_d  = n5_eff;
        n10_d = n10_eff;
        if (bus.req_valid) begin
          drink_d = bus.req_drink;
          if (plan_ok) begin
            sel_d      = bus.req_drink;
            issue      = 1'b1;
            issue_code = plan_coin0;
            coin1_d    = plan_coin1;
            more_d     = (plan_cnt == 2'd2);
            exp_chg_d  = plan_chg;
            state_d    = S_COIN;
          end else begin
            resp_valid_d  = 1'b1;
            resp_status_d = RESP_NO_FUNDS;
            state_d       = S_RESP;
          end
        end
      end

      S_COIN: begin
        if (more_q) begin
          more_d = 1'b0;
          if (COIN_GAP == 0) begin
            issue      = 1'b1;
            issue_code = coin1_q;
            state_d    = S_COIN;
          end else begin
            gap_d   = '0;
            state_d = S_GAP;
          end
        end else begin
          wait_d  = '0;
          state_d = S_WAIT;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d      = '0;
          issue      = 1'b1;
          issue_code = coin1_q;
          state_d    = S_COIN;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end

      S_WAIT: begin
        if (bus.drinks_in != 2'd0) begin
          if (bus.change_in && n5_q != CNT_MAX) begin
            n5_d = n5_q + CW'(1);
          end
          resp_valid_d  = 1'b1;
          resp_status_d = (bus.drinks_in == drink_code && bus.change_in == exp_chg_q)
                          ? RESP_OK : RESP_MISMATCH;
          sel_d         = 1'b0;
          state_d       = S_RESP;
        end else if (wait_q == WAIT_LAST) begin
          resp_valid_d  = 1'b1;
          resp_status_d = RESP_TIMEOUT;
          sel_d         = 1'b0;
          state_d       = S_RESP;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        sel_d   = 1'b0;
      end
    endcase

    // A coin leaves the inventory in the same cycle it appears on din
    if (issue) begin
      din_d = issue_code;
      if (issue_code == DIN_5) begin
        n5_d = n5_d - CW'(1);
      end else begin
        n10_d = n10_d - CW'(1);
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sel_q         <= 1'b0;
      din_q         <= DIN_NONE;
      resp_valid_q  <= 1'b0;
      resp_status_q <= RESP_OK;
      n5_q          <= '0;
      n10_q         <= '0;
      gap_q         <= '0;
      wait_q        <= '0;
      coin1_q       <= DIN_NONE;
      more_q        <= 1'b0;
      exp_chg_q     <= 1'b0;
      drink_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      din_q         <= din_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      n5_q          <= n5_d;
      n10_q         <= n10_d;
      gap_q         <= gap_d;
      wait_q        <= wait_d;
      coin1_q       <= coin1_d;
      more_q        <= more_d;
      exp_chg_q     <= exp_chg_d;
      drink_q       <= drink_d;
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.sel         = sel_q;
  assign bus.din         = din_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_status = resp_status_q;
  assign bus.n5_cnt      = n5_q;
  assign bus.n10_cnt     = n10_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_coin_feeder.sv
// Bench for coin_feeder: purchase driver, vending-block stub, and a
// monitor that checks coins and responses against expected queues.
module tb_coin_feeder;
  import vend_pkg::*;

  localparam int CW  = 8;
  localparam int GAP = 1;
  localparam int TMO = 8;
  localparam int CMAX = (1 << CW) - 1;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  coin_feeder_if #(.CW(CW)) bus();

  coin_feeder #(.CW(CW), .COIN_GAP(GAP), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Scoreboard state
  // coin entry: {cycle[15:0], din[1:0], sel, n5[CW-1:0], n10[CW-1:0]}
  // resp entry: {cycle[15:0], status[1:0], n5[CW-1:0], n10[CW-1:0]}
  logic [18+2*CW:0] exp_coin_q[$];
  logic [17+2*CW:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int resp_seen = 0;

  // Reference inventory
  int m5 = 0;
  int m10 = 0;

  // Vendor stub controls: 0 honest, 1 silent, 2 wrong drink, 3 wrong change
  int vend_mode = 0;
  int vend_delay = 0;
  int vend_sum = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: compares every coin and every response strobe
  initial begin
    logic [18+2*CW:0] ec;
    logic [17+2*CW:0] er;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.din != 2'd0) begin
          if (exp_coin_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL coin_unexpected: got din=%0d at cycle %0d, expected no coin", bus.din, cyc);
          end else begin
            ec = exp_coin_q.pop_front();
            check("coin", {16'(cyc), bus.din, bus.sel, bus.n5_cnt, bus.n10_cnt}, 64'(ec));
          end
        end
        if (bus.resp_valid) begin
          resp_seen++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_unexpected: got status=%0d at cycle %0d, expected no response", bus.resp_status, cyc);
          end else begin
            er = exp_q.pop_front();
            check("resp", {16'(cyc), bus.resp_status, bus.n5_cnt, bus.n10_cnt}, 64'(er));
            check("resp_sel", 64'(bus.sel), 64'(0));
          end
        end
      end
    end
  end

  // Vending block stub: collects coins, answers once the price is met
  initial begin
    logic [1:0] dr;
    logic       ch;
    int         price;
    bus.drinks_in = 2'd0;
    bus.change_in = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vend_sum = 0;
      end else if (bus.din != 2'd0) begin
        vend_sum += (bus.din == 2'd1) ? 5 : 10;
        price = bus.sel ? 10 : 5;
        if (vend_sum >= price) begin
          dr = bus.sel ? 2'd2 : 2'd1;
          ch = (vend_sum > price);
          vend_sum = 0;
          if (vend_mode != 1) begin
            if (vend_mode == 2) dr = bus.sel ? 2'd1 : 2'd2;
            if (vend_mode == 3) ch = ~ch;
            repeat (1 + vend_delay) @(negedge clk);
            bus.drinks_in = dr;
            bus.change_in = ch;
            @(negedge clk);
            bus.drinks_in = 2'd0;
            bus.change_in = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_idle(output bit ok);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    ok = bus.req_ready;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_ready_wait: got req_ready=0 after %0d cycles, expected 1", w);
    end
  endtask

  task automatic do_refill(input int r5, input int r10);
    bit ok;
    wait_idle(ok);
    if (ok) begin
      bus.refill_valid = 1'b1;
      bus.refill_n5    = CW'(r5);
      bus.refill_n10   = CW'(r10);
      @(posedge clk);
      #1;
      bus.refill_valid = 1'b0;
      m5  = r5;
      m10 = r10;
    end
  endtask

  // One purchase; the expected coin stream and response come from the
  // pricing rules and the vendor behaviour selected by mode.
  task automatic do_purchase(input logic drink, input bit refill, input int r5, input int r10,
                             input int mode, input int delay, input bit junk, input bit abort);
    bit ok;
    int a, w, start, price, paid, last, k, rc;
    logic [1:0] rd;
    int coins[$];
    resp_status_e st;

    start = resp_seen;
    wait_idle(ok);
    if (!ok) return;
    vend_mode  = mode;
    vend_delay = delay;
    bus.req_valid    = 1'b1;
    bus.req_drink    = drink;
    bus.refill_valid = refill;
    bus.refill_n5    = CW'(r5);
    bus.refill_n10   = CW'(r10);
    @(posedge clk);
    #1;
    a = cyc;
    bus.req_valid    = 1'b0;
    bus.refill_valid = 1'b0;

    if (refill) begin
      m5  = r5;
      m10 = r10;
    end
    price = drink ? 10 : 5;
    coins.delete();
    if (!drink) begin
      if (m5 >= 1) coins.push_back(5);
      else if (m10 >= 1) coins.push_back(10);
    end else begin
      if (m10 >= 1) coins.push_back(10);
      else if (m5 >= 2) begin coins.push_back(5); coins.push_back(5); end
    end

    if (coins.size() == 0) begin
      exp_q.push_back({16'(a), RESP_NO_FUNDS, CW'(m5), CW'(m10)});
    end else begin
      paid = 0;
      for (k = 0; k < coins.size(); k++) begin
        if (coins[k] == 5) m5--; else m10--;
        paid += coins[k];
        exp_coin_q.push_back({16'(a + k * (GAP + 1)), (coins[k] == 5) ? 2'd1 : 2'd2,
                              drink, CW'(m5), CW'(m10)});
      end
      last = a + (coins.size() - 1) * (GAP + 1);
      if (!abort) begin
        if (mode == 1) begin
          exp_q.push_back({16'(last + 1 + TMO), RESP_TIMEOUT, CW'(m5), CW'(m10)});
        end else begin
          rd = drink ? 2'd2 : 2'd1;
          rc = (paid > price) ? 1 : 0;
          if (mode == 2) rd = drink ? 2'd1 : 2'd2;
          if (mode == 3) rc = 1 - rc;
          st = (rd == (drink ? 2'd2 : 2'd1) && rc == ((paid > price) ? 1 : 0)) ? RESP_OK : RESP_MISMATCH;
          if (rc == 1 && m5 < CMAX) m5++;
          exp_q.push_back({16'(last + 2 + delay), st, CW'(m5), CW'(m10)});
        end
      end
    end

    // Refill outside IDLE must be ignored
    if (junk) begin
      bus.refill_valid = 1'b1;
      bus.refill_n5    = CW'($urandom_range(0, CMAX));
      bus.refill_n10   = CW'($urandom_range(0, CMAX));
      @(posedge clk);
      #1;
      bus.refill_valid = 1'b0;
    end

    if (abort) begin
      // Reset lands on the edge that ends the gap cycle
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort_din", 64'(bus.din), 64'(0));
      check("abort_sel", 64'(bus.sel), 64'(0));
      check("abort_n5", 64'(bus.n5_cnt), 64'(0));
      check("abort_n10", 64'(bus.n10_cnt), 64'(0));
      check("abort_resp_valid", 64'(bus.resp_valid), 64'(0));
      exp_coin_q.delete();
      m5  = 0;
      m10 = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end

    w = 0;
    while (resp_seen == start && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (resp_seen == start) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_wait: got no resp_valid within %0d cycles, expected one", w);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation time limit, expected $finish");
    $fatal(1, "watchdog expired");
  end

  // Main sequence: directed cases, then randomized purchases
  initial begin
    logic d;
    int   mode;
    bus.req_valid    = 1'b0;
    bus.req_drink    = 1'b0;
    bus.refill_valid = 1'b0;
    bus.refill_n5    = '0;
    bus.refill_n10   = '0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 64'(bus.state_dbg), 64'(S_IDLE));
    check("rst_req_ready", 64'(bus.req_ready), 64'(1));
    check("rst_sel", 64'(bus.sel), 64'(0));
    check("rst_din", 64'(bus.din), 64'(0));
    check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    check("rst_resp_status", 64'(bus.resp_status), 64'(0));
    check("rst_n5", 64'(bus.n5_cnt), 64'(0));
    check("rst_n10", 64'(bus.n10_cnt), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    do_refill(3, 0);
    do_purchase(DRINK_A, 0, 0, 0, 0, 0, 0, 0);   // single 5, OK
    do_refill(0, 1);
    do_purchase(DRINK_A, 0, 0, 0, 0, 0, 0, 0);   // 10 with change
    do_refill(2, 0);
    do_purchase(DRINK_B, 0, 0, 0, 0, 0, 0, 0);   // 5, gap, 5
    do_refill(1, 0);
    do_purchase(DRINK_B, 0, 0, 0, 0, 0, 0, 0);   // NO_FUNDS
    do_refill(1, 1);
    do_purchase(DRINK_B, 0, 0, 0, 1, 0, 0, 0);   // silent vendor
    do_refill(0, 3);
    do_purchase(DRINK_B, 0, 0, 0, 2, 0, 0, 0);   // wrong drink
    do_refill(CMAX, 1);
    do_purchase(DRINK_B, 0, 0, 0, 3, 0, 0, 0);   // forced change, n5 saturates
    do_refill(2, 0);
    do_purchase(DRINK_B, 0, 0, 0, 0, 0, 0, 1);   // reset during gap
    do_purchase(DRINK_A, 1, 4, 0, 0, 0, 0, 0);   // refill with request
    do_purchase(DRINK_A, 0, 0, 0, 0, 3, 1, 0);   // late reply, junk refill

    for (int i = 0; i < 40; i++) begin
      d = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 9);
      mode = (mode < 6) ? 0 : (mode - 6);
      do_purchase(d, ($urandom_range(0, 2) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                  mode, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 0);
    end

    repeat (4) @(negedge clk);
    check("coin_q_drained", 64'(exp_coin_q.size()), 64'(0));
    check("resp_q_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
